// File: rtl/seq_mem_pair_sequencer_if.sv
// Handshake and memory-control bundle between the pair sequencer and its datapath.
// Signal names are given from the sequencer's point of view (i_ = into it, o_ = out of it).
//   i_start, i_abort : job control
//   i_in_valid       : LOAD input stream valid
//   o_in_ready       : sequencer accepts an input word
//   o_wea, o_addr_a  : memory A write enable / address
//   o_latch_lo/hi    : operand latch strobes
//   o_web, o_addr_b  : memory B write enable / address
//   o_busy, o_done   : status
interface seq_mem_pair_sequencer_if #(
  parameter int unsigned ADDR_A_W = 3,
  parameter int unsigned ADDR_B_W = 2
);
  logic                i_start;
  logic                i_abort;
  logic                i_in_valid;
  logic                o_in_ready;
  logic                o_wea;
  logic [ADDR_A_W-1:0] o_addr_a;
  logic                o_latch_lo;
  logic                o_latch_hi;
  logic                o_web;
  logic [ADDR_B_W-1:0] o_addr_b;
  logic                o_busy;
  logic                o_done;

  modport master (
    input  i_start, i_abort, i_in_valid,
    output o_in_ready, o_wea, o_addr_a, o_latch_lo, o_latch_hi,
           o_web, o_addr_b, o_busy, o_done
  );

  modport slave (
    output i_start, i_abort, i_in_valid,
    input  o_in_ready, o_wea, o_addr_a, o_latch_lo, o_latch_hi,
           o_web, o_addr_b, o_busy, o_done
  );
endinterface

// File: rtl/seq_mem_pair_sequencer.sv
// Sequencer for the two-memory datapath: loads DEPTH_A words into memory A from a
// valid/ready stream, then reads A in (lo, hi) pairs, strobes the operand latches and
// writes one result per pair into memory B. Abort returns to idle from any state.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : control/handshake bundle (master side), see seq_mem_pair_sequencer_if
module seq_mem_pair_sequencer #(
  parameter int unsigned DEPTH_A  = 8,
  parameter int unsigned ADDR_A_W = 3,
  parameter int unsigned ADDR_B_W = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  seq_mem_pair_sequencer_if.master  bus
);

  localparam int unsigned LAST_A = DEPTH_A - 1;
  localparam int unsigned LAST_B = DEPTH_A / 2 - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RD_LO = 3'd2,
    S_RD_HI = 3'd3,
    S_WR_B  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_A_W-1:0] r_cnt_a;
  logic [ADDR_A_W-1:0] w_cnt_a_nxt;
  logic [ADDR_B_W-1:0] r_cnt_b;
  logic [ADDR_B_W-1:0] w_cnt_b_nxt;

  logic                r_in_ready;
  logic [ADDR_A_W-1:0] r_addr_a;
  logic                r_latch_lo;
  logic                r_latch_hi;
  logic                r_web;
  logic [ADDR_B_W-1:0] r_addr_b;
  logic                r_busy;
  logic                r_done;

  logic                w_in_ready_nxt;
  logic [ADDR_A_W-1:0] w_addr_a_nxt;
  logic                w_latch_lo_nxt;
  logic                w_latch_hi_nxt;
  logic                w_web_nxt;
  logic [ADDR_B_W-1:0] w_addr_b_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_xfer;

  // r_in_ready is high exactly in LOAD, so this is the stream handshake
  assign w_xfer = r_in_ready & bus.i_in_valid;

  // Next state and counters; abort overrides everything, including a LOAD transfer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    if (bus.i_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_a_nxt = '0;
      w_cnt_b_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            w_state_nxt = S_LOAD;
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            if (r_cnt_a == ADDR_A_W'(LAST_A)) begin
              w_state_nxt = S_RD_LO;
              w_cnt_a_nxt = '0;
            end else begin
              w_cnt_a_nxt = r_cnt_a + ADDR_A_W'(1);
            end
          end
        end
        S_RD_LO: begin
          w_state_nxt = S_RD_HI;
          w_cnt_a_nxt = r_cnt_a + ADDR_A_W'(1);
        end
        S_RD_HI: begin
          w_state_nxt = S_WR_B;
        end
        S_WR_B: begin
          if (r_cnt_b == ADDR_B_W'(LAST_B)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RD_LO;
            w_cnt_a_nxt = r_cnt_a + ADDR_A_W'(1);
            w_cnt_b_nxt = r_cnt_b + ADDR_B_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_a_nxt = '0;
          w_cnt_b_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_a_nxt = '0;
          w_cnt_b_nxt = '0;
        end
      endcase
    end
  end

  // Moore decode of the upcoming state, so registered outputs line up with r_state
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_addr_a_nxt   = '0;
    w_latch_lo_nxt = 1'b0;
    w_latch_hi_nxt = 1'b0;
    w_web_nxt      = 1'b0;
    w_addr_b_nxt   = '0;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = 1'b0;
    case (w_state_nxt)
      S_LOAD: begin
        w_in_ready_nxt = 1'b1;
        w_addr_a_nxt   = w_cnt_a_nxt;
      end
      S_RD_LO: begin
        w_latch_lo_nxt = 1'b1;
        w_addr_a_nxt   = w_cnt_a_nxt;
      end
      S_RD_HI: begin
        w_latch_hi_nxt = 1'b1;
        w_addr_a_nxt   = w_cnt_a_nxt;
      end
      S_WR_B: begin
        w_web_nxt    = 1'b1;
        w_addr_b_nxt = w_cnt_b_nxt;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_in_ready <= 1'b0;
      r_addr_a   <= '0;
      r_latch_lo <= 1'b0;
      r_latch_hi <= 1'b0;
      r_web      <= 1'b0;
      r_addr_b   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt_a    <= w_cnt_a_nxt;
      r_cnt_b    <= w_cnt_b_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_addr_a   <= w_addr_a_nxt;
      r_latch_lo <= w_latch_lo_nxt;
      r_latch_hi <= w_latch_hi_nxt;
      r_web      <= w_web_nxt;
      r_addr_b   <= w_addr_b_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // WEA follows InValid within the cycle so a word is written the cycle it is offered
  assign bus.o_wea      = w_xfer;
  assign bus.o_in_ready = r_in_ready;
  assign bus.o_addr_a   = r_addr_a;
  assign bus.o_latch_lo = r_latch_lo;
  assign bus.o_latch_hi = r_latch_hi;
  assign bus.o_web      = r_web;
  assign bus.o_addr_b   = r_addr_b;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;

endmodule

// File: tb/tb_seq_mem_pair_sequencer.sv
// Self-checking bench for seq_mem_pair_sequencer: directed scenarios plus a random run,
// all checked against a job-progress reference model (words loaded, processing step).
module tb_seq_mem_pair_sequencer;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned ADDR_A_W = 3;
  localparam int unsigned ADDR_B_W = 2;
  localparam int          STEPS    = 3 * DEPTH / 2;

  logic clk;
  logic rst_n;

  seq_mem_pair_sequencer_if #(.ADDR_A_W(ADDR_A_W), .ADDR_B_W(ADDR_B_W)) bus ();

  seq_mem_pair_sequencer #(
    .DEPTH_A (DEPTH),
    .ADDR_A_W(ADDR_A_W),
    .ADDR_B_W(ADDR_B_W)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;
  int n_done_seen;
  int n_wea_seen;
  int done_cyc;
  logic obs_busy;
  logic obs_done;

  // Reference model: where the current job is, in terms of words loaded and process steps
  bit m_busy;
  int m_loaded;
  int m_step;
  int m_jobs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d cyc=%0d t=%0t", tag, obs, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_loaded = 0;
    m_step   = 0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic v);
    if (a) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy   = 1'b1;
        m_loaded = 0;
        m_step   = 0;
      end
    end else if (m_loaded < DEPTH) begin
      if (v) m_loaded++;
    end else if (m_step < STEPS) begin
      m_step++;
      if (m_step == STEPS) m_jobs++;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs(input logic v);
    logic       e_ready, e_wea, e_lo, e_hi, e_web, e_done;
    int         e_addr_a, e_addr_b;
    int         p, ph;
    e_ready = 0; e_wea = 0; e_lo = 0; e_hi = 0; e_web = 0; e_done = 0;
    e_addr_a = 0; e_addr_b = 0;
    if (m_busy) begin
      if (m_loaded < DEPTH) begin
        e_ready  = 1;
        e_wea    = v;
        e_addr_a = m_loaded;
      end else if (m_step < STEPS) begin
        p  = m_step / 3;
        ph = m_step % 3;
        if (ph == 0) begin e_lo = 1; e_addr_a = 2 * p; end
        else if (ph == 1) begin e_hi = 1; e_addr_a = 2 * p + 1; end
        else begin e_web = 1; e_addr_b = p; end
      end else begin
        e_done = 1;
      end
    end
    chk("busy",     32'(bus.o_busy),     32'(m_busy));
    chk("in_ready", 32'(bus.o_in_ready), 32'(e_ready));
    chk("wea",      32'(bus.o_wea),      32'(e_wea));
    chk("addr_a",   32'(bus.o_addr_a),   32'(e_addr_a));
    chk("latch_lo", 32'(bus.o_latch_lo), 32'(e_lo));
    chk("latch_hi", 32'(bus.o_latch_hi), 32'(e_hi));
    chk("web",      32'(bus.o_web),      32'(e_web));
    chk("addr_b",   32'(bus.o_addr_b),   32'(e_addr_b));
    chk("done",     32'(bus.o_done),     32'(e_done));
    chk("strobe_mutex",
        32'(int'(bus.o_wea) + int'(bus.o_web) + int'(bus.o_latch_lo) + int'(bus.o_latch_hi) <= 1),
        32'd1);
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge
  task automatic cycle(input logic s, input logic a, input logic v);
    bus.i_start    = s;
    bus.i_abort    = a;
    bus.i_in_valid = v;
    #2;
    check_outputs(v);
    obs_busy = bus.o_busy;
    obs_done = bus.o_done;
    if (bus.o_done) begin
      n_done_seen++;
      done_cyc = cyc;
    end
    if (bus.o_wea) n_wea_seen++;
    @(posedge clk);
    model_step(s, a, v);
    #1;
    cyc++;
  endtask

  task automatic run_to_done(input int max_cycles, input logic v);
    for (int i = 0; i < max_cycles; i++) begin
      cycle(1'b0, 1'b0, v);
      if (obs_done) break;
    end
  endtask

  int t0;
  int wea0;
  int done0;
  int idle_gap;
  bit seen_done;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; n_done_seen = 0; n_wea_seen = 0;
    done_cyc = -1; m_jobs = 0;
    obs_busy = 0; obs_done = 0;
    bus.i_start = 0; bus.i_abort = 0; bus.i_in_valid = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // Reset mid-LOAD after three transfers
    cycle(1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    bus.i_in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",     32'(bus.o_busy),     32'd0);
    chk("rst_in_ready", 32'(bus.o_in_ready), 32'd0);
    chk("rst_wea",      32'(bus.o_wea),      32'd0);
    chk("rst_addr_a",   32'(bus.o_addr_a),   32'd0);
    chk("rst_latch",    32'(bus.o_latch_lo | bus.o_latch_hi), 32'd0);
    chk("rst_web",      32'(bus.o_web),      32'd0);
    chk("rst_done",     32'(bus.o_done),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Back-to-back full job: latency and write count
    t0 = cyc; wea0 = n_wea_seen; done_cyc = -1;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_done(40, 1'b1);
    chk("lat_full", 32'(done_cyc - t0), 32'd21);
    chk("writes_full", 32'(n_wea_seen - wea0), 32'd8);
    cycle(1'b0, 1'b0, 1'b0);

    // Stalling input: 1,0,0 pattern
    wea0 = n_wea_seen; done_cyc = -1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 80; i++) begin
      cycle(1'b0, 1'b0, (i % 3) == 0);
      if (obs_done) break;
    end
    chk("writes_stall", 32'(n_wea_seen - wea0), 32'd8);
    chk("done_stall", 32'(done_cyc >= 0), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);

    // Abort in RD_HI of the second pair
    t0 = cyc; done0 = n_done_seen;
    cycle(1'b1, 1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 1'b1);
    chk("abort_at_rdhi", 32'(bus.o_latch_hi), 32'd1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    repeat (25) cycle(1'b0, 1'b0, 1'b0);
    chk("abort_no_done", 32'(n_done_seen - done0), 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("restart_addr", 32'(bus.o_addr_a), 32'd0);
    run_to_done(40, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Start pulses while busy are ignored
    t0 = cyc; done_cyc = -1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 40; i++) begin
      cycle((i == 3) || (i == 11), 1'b0, 1'b1);
      if (obs_done) break;
    end
    chk("lat_ignore_start", 32'(done_cyc - t0), 32'd21);
    cycle(1'b0, 1'b0, 1'b0);

    // Start held high across DONE: one idle cycle between jobs
    seen_done = 0; idle_gap = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (seen_done && !obs_busy) idle_gap++;
      if (seen_done && obs_busy) break;
      if (obs_done) seen_done = 1;
    end
    chk("held_start_gap", 32'(idle_gap), 32'd1);
    run_to_done(40, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Random run
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0));
    end
    repeat (30) cycle(1'b0, 1'b0, 1'b1);
    chk("done_count", 32'(n_done_seen), 32'(m_jobs));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
